// File: rtl/mpmc9_strm_read_cache_p.sv
// mpmc9_strm_read_cache_p
// Direct-mapped stream read cache for the mpmc9 streaming read ports. It
// holds recently fetched lines so that repeated stream reads hit without a
// DRAM access.
//
// Ports
//   clk        sole clock
//   rst        synchronous active-high reset; also starts an invalidate sweep
//   wr/wadr/wdat   line fill (byte address, full line data)
//   inv/iadr       invalidate the single line indexed by iadr
//   inv_all        pulse: (re)start the invalidate-all sweep
//   busy           sweep in progress
//   rd/radr        lookup request (byte address), one per cycle, no stall
//   rvalid/rdat/hit  lookup result, two edges after rd is sampled
//   clr_stats      zero both statistics counters
//   hit_cnt/miss_cnt  saturating lookup statistics
//
// Index = adr[OB+IB-1:OB]; the tag stored is the whole line address
// adr[AWID-1:OB], so a hit compares the complete line address.
module mpmc9_strm_read_cache_p #(
  parameter int AWID  = 32,
  parameter int DWID  = 128,
  parameter int DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr,
  input  logic [AWID-1:0] wadr,
  input  logic [DWID-1:0] wdat,
  input  logic            inv,
  input  logic [AWID-1:0] iadr,
  input  logic            inv_all,
  output logic            busy,
  input  logic            rd,
  input  logic [AWID-1:0] radr,
  output logic            rvalid,
  output logic [DWID-1:0] rdat,
  output logic            hit,
  input  logic            clr_stats,
  output logic [31:0]     hit_cnt,
  output logic [31:0]     miss_cnt
);

  localparam int OB = $clog2(DWID / 8);
  localparam int IB = $clog2(DEPTH);
  localparam int TW = AWID - OB;
  localparam logic [IB-1:0] SLAST = IB'(DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t        state_q, state_nxt;
  logic [IB-1:0] sidx_q, sidx_nxt;

  logic [DWID-1:0] line_mem [DEPTH];
  logic [TW-1:0]   tag_mem  [DEPTH];
  logic            vld_mem  [DEPTH];

  logic [IB-1:0] widx, iidx, ridx_p0;
  logic [TW-1:0] wtag, rla_p0;
  logic          wr_en, inv_en, sweep_clr;

  logic            vld_p0;
  logic [AWID-1:0] radr_p0;

  logic            vld_p1, fwd_p1, kill_p1, vbit_rd_p1;
  logic [DWID-1:0] line_rd_p1, fwd_dat_p1;
  logic [TW-1:0]   tag_rd_p1, fwd_tag_p1, rla_p1;

  logic            fwd, kill;
  logic [DWID-1:0] line_s2;
  logic [TW-1:0]   tag_s2;
  logic            vbit_s2, hit_s2;

  logic unused_bits;
  assign unused_bits = ^{wadr, iadr, radr_p0};

  assign busy = (state_q == SWEEP);

  assign widx    = wadr[OB+IB-1:OB];
  assign wtag    = wadr[AWID-1:OB];
  assign iidx    = iadr[OB+IB-1:OB];
  assign ridx_p0 = radr_p0[OB+IB-1:OB];
  assign rla_p0  = radr_p0[AWID-1:OB];

  // Fills and single invalidates are locked out while sweeping or restarting.
  assign wr_en     = wr  && !busy && !inv_all && !rst;
  assign inv_en    = inv && !busy && !inv_all && !rst;
  assign sweep_clr = busy && !inv_all && !rst;

  // Sweep FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SWEEP;
      sidx_q  <= '0;
    end else begin
      state_q <= state_nxt;
      sidx_q  <= sidx_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    sidx_nxt  = sidx_q;
    if (inv_all) begin
      state_nxt = SWEEP;
      sidx_nxt  = '0;
    end else if (state_q == SWEEP) begin
      sidx_nxt = sidx_q + 1'b1;
      if (sidx_q == SLAST) state_nxt = IDLE;
    end
  end

  // Line and tag RAM: one write port, one synchronous read-before-write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_mem[widx] <= wdat;
      tag_mem[widx]  <= wtag;
    end
    line_rd_p1 <= line_mem[ridx_p0];
    tag_rd_p1  <= tag_mem[ridx_p0];
  end

  // Valid RAM. wr is applied after inv so it wins on a shared index.
  always_ff @(posedge clk) begin
    if (sweep_clr) begin
      vld_mem[sidx_q] <= 1'b0;
    end else begin
      if (inv_en) vld_mem[iidx] <= 1'b0;
      if (wr_en)  vld_mem[widx] <= 1'b1;
    end
    vbit_rd_p1 <= vld_mem[ridx_p0];
  end

  // ---- stage 0: register the request ----
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= rd;
    radr_p0 <= radr;
  end

  // ---- stage 1: RAM read plus same-edge write/invalidate bypass ----
  // The RAM read returns pre-edge contents, so anything written on this very
  // edge is carried alongside and merged in stage 2.
  assign fwd  = wr_en && (widx == ridx_p0);
  assign kill = busy || inv_all || (inv_en && (iidx == ridx_p0));

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
    fwd_p1     <= fwd;
    kill_p1    <= kill;
    fwd_dat_p1 <= wdat;
    fwd_tag_p1 <= wtag;
    rla_p1     <= rla_p0;
  end

  // ---- stage 2: tag compare and result register ----
  // A result delivered while the sweep is (still or newly) running is a miss.
  assign line_s2 = fwd_p1 ? fwd_dat_p1 : line_rd_p1;
  assign tag_s2  = fwd_p1 ? fwd_tag_p1 : tag_rd_p1;
  assign vbit_s2 = fwd_p1 || (vbit_rd_p1 && !kill_p1);
  assign hit_s2  = vld_p1 && vbit_s2 && (tag_s2 == rla_p1) && (state_nxt != SWEEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      hit    <= 1'b0;
      rdat   <= '0;
    end else begin
      rvalid <= vld_p1;
      hit    <= hit_s2;
      if (vld_p1) rdat <= line_s2;
    end
  end

  // Counters update on the same edge that registers the result.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (vld_p1) begin
      if (hit_s2) hit_cnt  <= sat_inc(hit_cnt);
      else        miss_cnt <= sat_inc(miss_cnt);
    end
  end

endmodule

// File: tb/tb_mpmc9_strm_read_cache_p.sv
module tb_mpmc9_strm_read_cache_p;

  localparam int AWID  = 32;
  localparam int DWID  = 128;
  localparam int DEPTH = 256;
  localparam int OB    = $clog2(DWID / 8);
  localparam int IB    = $clog2(DEPTH);
  localparam int TW    = AWID - OB;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr = 1'b0, inv = 1'b0, inv_all = 1'b0, rd = 1'b0, clr_stats = 1'b0;
  logic [AWID-1:0] wadr = '0, iadr = '0, radr = '0;
  logic [DWID-1:0] wdat = '0;
  logic            busy, rvalid, hit;
  logic [DWID-1:0] rdat;
  logic [31:0]     hit_cnt, miss_cnt;

  mpmc9_strm_read_cache_p #(.AWID(AWID), .DWID(DWID), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr(wr), .wadr(wadr), .wdat(wdat), .inv(inv), .iadr(iadr),
    .inv_all(inv_all), .busy(busy), .rd(rd), .radr(radr), .rvalid(rvalid), .rdat(rdat),
    .hit(hit), .clr_stats(clr_stats), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [DWID-1:0] PAT_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [DWID-1:0] PAT_B = 128'hB0B0_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [DWID-1:0] PAT_C = 128'hC0DE_C0DE_0000_FFFF_1234_5678_9ABC_DEF0;

  // ---------------- behavioural model ----------------
  // Cache contents as the rules define them; a lookup sampled at edge N sees
  // the contents as they stand after edge N+1, and is a miss if the sweep was
  // running around edge N+1 or after edge N+2.
  bit              m_init = 1'b0;
  int              m_left = 0;
  bit              m_valid [DEPTH];
  logic [TW-1:0]   m_tag   [DEPTH];
  logic [DWID-1:0] m_line  [DEPTH];
  bit              q1_v = 1'b0, q2_v = 1'b0, q2_hit = 1'b0;
  logic [AWID-1:0] q1_adr = '0;
  logic [DWID-1:0] q2_dat = '0;
  bit              exp_rvalid = 1'b0, exp_hit = 1'b0, exp_busy = 1'b0;
  logic [DWID-1:0] exp_rdat = '0;
  logic [31:0]     m_hc = '0, m_mc = '0;
  bit              sat_req = 1'b0;

  function automatic int idx_of(input logic [AWID-1:0] a);
    return int'(a[OB+IB-1:OB]);
  endfunction

  always @(posedge clk) begin
    bit busy_before, busy_after;
    int i;
    busy_before = (m_left > 0);
    if (rst) begin
      m_init = 1'b1;
      m_left = DEPTH;
      q1_v = 1'b0; q2_v = 1'b0;
      exp_rvalid = 1'b0; exp_hit = 1'b0; exp_rdat = '0;
      m_hc = '0; m_mc = '0;
    end else begin
      if (sat_req) m_hc = 32'hFFFF_FFFF;
      if (inv_all) m_left = DEPTH;
      else if (m_left > 0) begin
        m_valid[DEPTH - m_left] = 1'b0;
        m_left = m_left - 1;
      end else begin
        if (inv) m_valid[idx_of(iadr)] = 1'b0;
        if (wr) begin
          m_valid[idx_of(wadr)] = 1'b1;
          m_tag[idx_of(wadr)]   = wadr[AWID-1:OB];
          m_line[idx_of(wadr)]  = wdat;
        end
      end
      busy_after = (m_left > 0);
      exp_rvalid = q2_v;
      exp_hit    = q2_v && q2_hit && !busy_after;
      if (q2_v) exp_rdat = q2_dat;
      if (clr_stats) begin
        m_hc = '0; m_mc = '0;
      end else if (q2_v) begin
        if (exp_hit) begin if (m_hc != 32'hFFFF_FFFF) m_hc = m_hc + 1; end
        else         begin if (m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1; end
      end
      q2_v = q1_v;
      if (q1_v) begin
        i = idx_of(q1_adr);
        q2_hit = m_valid[i] && (m_tag[i] == q1_adr[AWID-1:OB]) && !busy_before && !busy_after;
        q2_dat = m_line[i];
      end
      q1_v   = rd;
      q1_adr = radr;
    end
    exp_busy = (m_left > 0);
  end

  // ---------------- checking ----------------
  int n_cmp = 0, n_fail = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkd(input string nm, input logic [DWID-1:0] act, input logic [DWID-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    if (!m_init) return;
    chk1("model_rvalid", rvalid, exp_rvalid);
    chk1("model_busy", busy, exp_busy);
    if (exp_rvalid) chk1("model_hit", hit, exp_hit);
    if (exp_rvalid && exp_hit) chkd("model_rdat", rdat, exp_rdat);
    chk32("model_hit_cnt", hit_cnt, m_hc);
    chk32("model_miss_cnt", miss_cnt, m_mc);
  endtask

  // One clock: inputs set beforehand are sampled, outputs checked on the
  // falling edge, then single-cycle strobes drop.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    cmp_model();
    rd = 1'b0; wr = 1'b0; inv = 1'b0; inv_all = 1'b0; clr_stats = 1'b0;
  endtask

  task automatic lookup_result(input logic [AWID-1:0] a, input string nm, input logic exp_h);
    rd = 1'b1; radr = a;
    cyc();
    cyc();
    chk1({nm, "_early"}, rvalid, 1'b0);
    cyc();
    chk1({nm, "_rvalid"}, rvalid, 1'b1);
    chk1({nm, "_hit"}, hit, exp_h);
  endtask

  task automatic do_wr(input logic [AWID-1:0] a, input logic [DWID-1:0] d);
    wr = 1'b1; wadr = a; wdat = d;
  endtask

  initial begin
    // reset
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk1("rst_busy", busy, 1'b1);
    chk1("rst_rvalid", rvalid, 1'b0);
    chk1("rst_hit", hit, 1'b0);
    chkd("rst_rdat", rdat, '0);
    chk32("rst_hit_cnt", hit_cnt, 32'd0);
    chk32("rst_miss_cnt", miss_cnt, 32'd0);

    // sweep after reset, with a lookup in the middle
    for (int i = 1; i <= 256; i++) begin
      if (i == 10) begin rd = 1'b1; radr = 32'h0000_0100; end
      cyc();
      if (i == 11) chk1("sweep_lk_early", rvalid, 1'b0);
      if (i == 12) begin
        chk1("sweep_lk_rvalid", rvalid, 1'b1);
        chk1("sweep_lk_hit", hit, 1'b0);
        chk32("sweep_lk_miss_cnt", miss_cnt, 32'd1);
      end
      if (i == 255) chk1("sweep_busy_255", busy, 1'b1);
      if (i == 256) chk1("sweep_busy_256", busy, 1'b0);
    end

    // fill then hit, then same index with another tag
    do_wr(32'h0000_1230, PAT_A);
    cyc();
    lookup_result(32'h0000_1238, "fill_hit", 1'b1);
    chkd("fill_rdat", rdat, PAT_A);
    chk32("fill_hit_cnt", hit_cnt, 32'd1);
    lookup_result(32'h0010_1230, "tag_miss", 1'b0);
    chk32("tag_miss_cnt", miss_cnt, 32'd2);

    // bypass: write one edge after the lookup is sampled
    rd = 1'b1; radr = 32'h0000_2000;
    cyc();
    do_wr(32'h0000_2000, PAT_B);
    cyc();
    cyc();
    chk1("byp_rvalid", rvalid, 1'b1);
    chk1("byp_hit", hit, 1'b1);
    chkd("byp_rdat", rdat, PAT_B);
    chk32("byp_hit_cnt", hit_cnt, 32'd2);
    // write two edges after: too late
    inv = 1'b1; iadr = 32'h0000_2000;
    cyc();
    cyc();
    rd = 1'b1; radr = 32'h0000_2000;
    cyc();
    cyc();
    do_wr(32'h0000_2000, PAT_C);
    cyc();
    chk1("late_rvalid", rvalid, 1'b1);
    chk1("late_hit", hit, 1'b0);
    chk32("late_miss_cnt", miss_cnt, 32'd3);

    // wr and inv on one index at once: wr wins
    do_wr(32'h0000_3000, PAT_C);
    inv = 1'b1; iadr = 32'h0000_3000;
    cyc();
    lookup_result(32'h0000_3000, "wrinv", 1'b1);
    chkd("wrinv_rdat", rdat, PAT_C);
    inv = 1'b1; iadr = 32'h0000_3000;
    cyc();
    lookup_result(32'h0000_3000, "inv", 1'b0);
    chk32("inv_miss_cnt", miss_cnt, 32'd4);

    // back-to-back alternating hits and misses
    clr_stats = 1'b1;
    cyc();
    chk32("clr_hit_cnt", hit_cnt, 32'd0);
    chk32("clr_miss_cnt", miss_cnt, 32'd0);
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin
        rd = 1'b1;
        radr = ((i % 2) == 0) ? 32'h0000_1230 : 32'h0010_1230;
      end
      cyc();
      if (i >= 2) begin
        chk1("stream_rvalid", rvalid, 1'b1);
        chk1("stream_hit", hit, ((i % 2) == 0));
      end
    end
    cyc();
    chk1("stream_end", rvalid, 1'b0);
    chk32("stream_hit_cnt", hit_cnt, 32'd5);
    chk32("stream_miss_cnt", miss_cnt, 32'd5);

    // clr_stats on the same edge as a hit result
    rd = 1'b1; radr = 32'h0000_1230;
    cyc();
    cyc();
    clr_stats = 1'b1;
    cyc();
    chk1("clrhit_rvalid", rvalid, 1'b1);
    chk1("clrhit_hit", hit, 1'b1);
    chk32("clrhit_hit_cnt", hit_cnt, 32'd0);
    chk32("clrhit_miss_cnt", miss_cnt, 32'd0);

    // hit counter saturation
    force dut.hit_cnt = 32'hFFFF_FFFF;
    sat_req = 1'b1;
    #1;
    release dut.hit_cnt;
    rd = 1'b1; radr = 32'h0000_1230;
    cyc();
    sat_req = 1'b0;
    cyc();
    cyc();
    chk1("sat_hit", hit, 1'b1);
    chk32("sat_hit_cnt", hit_cnt, 32'hFFFF_FFFF);

    // inv_all, then restart mid-sweep; fills are ignored while busy
    inv_all = 1'b1;
    cyc();
    chk1("invall_busy", busy, 1'b1);
    for (int j = 0; j < 100; j++) begin
      if (j == 5) do_wr(32'h0000_4000, PAT_A);
      if (j == 20) begin rd = 1'b1; radr = 32'h0000_1230; end
      cyc();
    end
    inv_all = 1'b1;
    cyc();
    for (int k = 1; k <= 256; k++) begin
      cyc();
      if (k == 255) chk1("restart_busy_255", busy, 1'b1);
      if (k == 256) chk1("restart_busy_256", busy, 0);
    end
    lookup_result(32'h0000_1230, "swept", 1'b0);
    lookup_result(32'h0000_4000, "ignored_wr", 1'b0);

    // reset drops a lookup in flight
    do_wr(32'h0000_5000, PAT_B);
    cyc();
    rd = 1'b1; radr = 32'h0000_5000;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk1("rstdrop_rvalid", rvalid, 1'b0);
    cyc();
    chk1("rstdrop_rvalid2", rvalid, 1'b0);
    chk32("rstdrop_hit_cnt", hit_cnt, 32'd0);
    for (int k = 0; k < 260; k++) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
